// File: rtl/fu_arb_pkg.sv
// Shared types and opcode constants for the functional-unit arbiter.
package fu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LAND = 4'd6;
  localparam logic [3:0] OP_LOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_MAD  = 4'd9;
  localparam logic [3:0] OP_MAX  = 4'd9;

endpackage

// File: rtl/functional_unit.sv
// Combinational 4-bit operand / 8-bit result functional unit.
// Results wrap modulo 256; unknown opcodes produce zero.
module functional_unit
  import fu_arb_pkg::*;
(
  input  logic [3:0] m_i,
  input  logic [3:0] n_i,
  input  logic [3:0] sel_i,
  output logic [7:0] res_o
);

  logic [7:0] m8;
  logic [7:0] n8;

  assign m8 = {4'd0, m_i};
  assign n8 = {4'd0, n_i};

  // Opcode decode; every arm is computed in 8 bits so sub/mad wrap naturally.
  always_comb begin
    res_o = 8'd0;
    case (sel_i)
      OP_ADD:  res_o = m8 + n8;
      OP_SUB:  res_o = m8 - n8;
      OP_MUL:  res_o = m8 * n8;
      OP_AND:  res_o = m8 & n8;
      OP_OR:   res_o = m8 | n8;
      OP_XOR:  res_o = m8 ^ n8;
      OP_LAND: res_o = {7'd0, (|m_i) & (|n_i)};
      OP_LOR:  res_o = {7'd0, (|m_i) | (|n_i)};
      OP_NOT:  res_o = ~m8;
      OP_MAD:  res_o = (m8 + m8 + m8) - n8;
      default: res_o = 8'd0;
    endcase
  end

endmodule

// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one functional unit between NUM_REQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module fu_arbiter
  import fu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_m,
  input  logic [NUM_REQ*4-1:0] req_n,
  input  logic [NUM_REQ*4-1:0] req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [15:0]          op_count
);

  state_e            state_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [7:0]        rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic [15:0]       op_count_q;
  logic [15:0]       op_count_d;

  logic [3:0]        op_m_q;
  logic [3:0]        op_n_q;
  logic [3:0]        op_sel_q;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [3:0]        win_m;
  logic [3:0]        win_n;
  logic [3:0]        win_sel;
  logic [7:0]        fu_res;
  logic              accept;

  assign op_count_d = op_count_q + 16'd1;
  assign accept     = (state_q == S_IDLE) && win_found;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned     cand;
    logic [ID_W-1:0] cand_id;
    cand      = 0;
    cand_id   = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(last_grant_q) + k) % NUM_REQ;
      cand_id = cand[ID_W-1:0];
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  // Only the winner sees ready, and only while the unit is idle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  assign win_m   = req_m[win_idx*4 +: 4];
  assign win_n   = req_n[win_idx*4 +: 4];
  assign win_sel = req_sel[win_idx*4 +: 4];

  // Operand capture on the accept edge; contents are don't-care outside EXEC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_m_q   <= win_m;
      op_n_q   <= win_n;
      op_sel_q <= win_sel;
    end
  end

  functional_unit u_fu (
    .m_i   (op_m_q),
    .n_i   (op_n_q),
    .sel_i (op_sel_q),
    .res_o (fu_res)
  );

  // Control FSM with registered response and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_data_q   <= 8'd0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            rsp_id_q     <= win_idx;
            last_grant_q <= win_idx;
            busy_q       <= 1'b1;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data_q  <= fu_res;
          rsp_err_q   <= (op_sel_q > OP_MAX);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Self-checking bench for fu_arbiter: a negedge reference model pushes the
// expected response at each grant and pops it when the handshake completes.
module tb_fu_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*4-1:0] req_m;
  logic [NR*4-1:0] req_n;
  logic [NR*4-1:0] req_sel;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [15:0]     op_count;

  always #5 clk = ~clk;

  fu_arbiter #(.NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m     (req_m),
    .req_n     (req_n),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] fu_model(input logic [3:0] m, input logic [3:0] n,
                                          input logic [3:0] sel);
    int mi;
    int ni;
    int r;
    mi = int'(m);
    ni = int'(n);
    case (int'(sel))
      0: r = mi + ni;
      1: r = mi - ni;
      2: r = mi * ni;
      3: r = mi & ni;
      4: r = mi | ni;
      5: r = mi ^ ni;
      6: r = (mi != 0 && ni != 0) ? 1 : 0;
      7: r = (mi != 0 || ni != 0) ? 1 : 0;
      8: r = ~mi;
      9: r = 3 * mi - ni;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef enum {P_IDLE, P_EXEC, P_RESP} ph_t;

  exp_t        sb[$];
  ph_t         ph = P_IDLE;
  int          tb_last = NR - 1;
  logic [15:0] tb_cnt = 16'd0;
  bit          granted2 = 1'b0;

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    int            w;
    int            c;
    exp_t          e;
    if (!rst_n) begin
      ph      = P_IDLE;
      tb_last = NR - 1;
      tb_cnt  = 16'd0;
      sb.delete();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_count", op_count, 0);
    end else begin
      exp_rdy = '0;
      w = -1;
      if (ph == P_IDLE) begin
        for (int k = 1; k <= NR; k++) begin
          c = (tb_last + k) % NR;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("ready", req_ready, exp_rdy);
      chk("busy", busy, ph != P_IDLE);
      chk("rsp_valid", rsp_valid, ph == P_RESP);
      chk("op_count", op_count, tb_cnt);
      case (ph)
        P_IDLE: begin
          if (w >= 0) begin
            e.id   = w;
            e.data = fu_model(req_m[w*4 +: 4], req_n[w*4 +: 4], req_sel[w*4 +: 4]);
            e.err  = (req_sel[w*4 +: 4] > 4'd9);
            sb.push_back(e);
            if (w == 2) granted2 = 1'b1;
            tb_last = w;
            ph = P_EXEC;
          end
        end
        P_EXEC: ph = P_RESP;
        default: begin
          chk("sb_size", sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb[0];
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            if (rsp_ready) begin
              void'(sb.pop_front());
              tb_cnt = tb_cnt + 16'd1;
              ph = P_IDLE;
            end
          end
        end
      endcase
    end
  end

  task automatic drive_op(input int r, input logic [3:0] m, input logic [3:0] n,
                          input logic [3:0] sel);
    req_m[r*4 +: 4]   = m;
    req_n[r*4 +: 4]   = n;
    req_sel[r*4 +: 4] = sel;
    req_valid[r]      = 1'b1;
  endtask

  // Wait for requester r to be granted, then drop its request after the accept edge.
  task automatic wait_grant(input int r);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    chk($sformatf("grant_seen_r%0d", r), got, 1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic [3:0] m, input logic [3:0] n,
                       input logic [3:0] sel);
    drive_op(r, m, n, sel);
    wait_grant(r);
  endtask

  // Wait for a response, compare against spec-derived constants, step past the edge.
  task automatic wait_rsp(input string tag, input logic [7:0] d, input logic er,
                          input int id, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, "_seen"}, got, 1);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_err"}, rsp_err, er);
    chk({tag, "_id"}, rsp_id, id);
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < NR; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  initial begin
    int  wt;
    int  gid;
    bit  got;
    req_valid = '0;
    req_m     = '0;
    req_n     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);
    @(posedge clk);
    #1;

    // Single op: 2 - 5 wraps to 0xFD, valid two cycles after accept.
    rsp_ready = 1'b1;
    issue(0, 4'd2, 4'd5, 4'd1);
    wait_rsp("single", 8'hFD, 1'b0, 0, wt);
    chk("single_latency", wt, 2);

    // Fairness from a fresh reset: order 0,1,2,3,0.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 0; r < NR; r++) drive_op(r, 4'(r + 1), 4'(r + 2), 4'(r));
    for (int g = 0; g < 5; g++) begin
      got = 1'b0;
      gid = -1;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          got = 1'b1;
          gid = onehot_idx(req_ready);
        end
      end
      chk($sformatf("fair_grant%0d", g), gid, g % NR);
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(negedge clk);
    chk("fair_count", op_count, 5);
    @(posedge clk);
    #1;

    // Backpressure: 3*15-0 = 45 held while another requester waits.
    rsp_ready = 1'b0;
    issue(1, 4'd15, 4'd0, 4'd9);
    drive_op(3, 4'd4, 4'd9, 4'd7);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_seen", got, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 8'h2D);
      chk("bp_no_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(3);
    wait_rsp("bp_lor", 8'h01, 1'b0, 3, wt);

    // Illegal opcode, then bitwise NOT.
    issue(2, 4'd7, 4'd3, 4'd12);
    wait_rsp("illegal", 8'h00, 1'b1, 2, wt);
    issue(0, 4'd5, 4'd0, 4'd8);
    wait_rsp("not", 8'hFA, 1'b0, 0, wt);

    // Reset during EXEC: the in-flight result is dropped and priority restarts at 0.
    issue(0, 4'd3, 4'd3, 4'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    drive_op(1, 4'd3, 4'd4, 4'd2);
    drive_op(0, 4'd6, 4'd2, 4'd5);
    got = 1'b0;
    gid = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        gid = onehot_idx(req_ready);
      end
    end
    chk("post_rst_grant", gid, 0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp("post_rst_xor", 8'h04, 1'b0, 0, wt);
    wait_grant(1);
    wait_rsp("post_rst_mul", 8'h0C, 1'b0, 1, wt);

    // Withdrawal of requester 2 and op_count wrap from 0xFFFE.
    force dut.op_count_q = 16'hFFFE;
    tb_cnt = 16'hFFFE;
    #1 release dut.op_count_q;
    granted2 = 1'b0;
    issue(0, 4'd1, 4'd1, 4'd0);
    drive_op(2, 4'd9, 4'd9, 4'd0);
    drive_op(3, 4'd2, 4'd2, 4'd2);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    wait_rsp("wd_add", 8'h02, 1'b0, 0, wt);
    wait_grant(3);
    wait_rsp("wd_mul", 8'h04, 1'b0, 3, wt);
    @(negedge clk);
    chk("wrap_count", op_count, 0);
    chk("never_granted2", granted2, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fu_arbiter.md
FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter ID_W, default $clog2(NUM_REQ): requester index width; derived, never overridden.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_m, req_n  in  NUM_REQ*4 each  packed operands; slice i belongs to requester i.
REQ-009 req_sel  in  NUM_REQ*4  packed opcode per requester.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer accepts result.
REQ-012 rsp_id  out  ID_W  index of the requester that owns the result.
REQ-013 rsp_data  out  8  result.
REQ-014 rsp_err  out  1  captured opcode was > 9.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 op_count  out  16  completed responses, wrapping.

Function
REQ-017 FSM states SHALL be IDLE, EXEC and RESP.
REQ-018 IDLE: if any req_valid is high, SHALL grant one requester round-robin, searching from last_grant+1 modulo NUM_REQ.
REQ-019 In IDLE, req_ready[w] SHALL be driven combinationally high for the winner w only; all bits SHALL be 0 outside IDLE and when no req_valid is high.
REQ-020 On the accept edge: capture req_m/n/sel[w] and w; set last_grant=w; go to EXEC.
REQ-021 EXEC (1 cycle): drive the captured operands into the functional unit; register its output into rsp_data and (sel>9) into rsp_err; go to RESP.
REQ-022 RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_valid && rsp_ready; then go to IDLE and increment op_count.
REQ-023 Latency: accept in cycle T gives rsp_valid in cycle T+2; minimum issue interval is 3 cycles.
REQ-024 rsp_ready already high when rsp_valid rises SHALL complete the handshake in that cycle.
REQ-025 Result arithmetic SHALL equal the functional unit's 8-bit result: opcodes 0-9 = add, sub, mul, and, or, xor, logical-and, logical-or, not, 3m-n; sub and 3m-n wrap modulo 256; opcodes >9 give 0.
REQ-026 A requester that lowers req_valid before being granted SHALL lose nothing and affect no state.
REQ-027 Requests arriving in EXEC/RESP SHALL wait; there is no queueing beyond the single in-flight operation.
REQ-028 op_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-029 Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, op_count=0, req_ready=0.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight operation; no response is produced for it.

Structure
REQ-031 Package fu_arb_pkg SHALL hold the state enum, the opcode constants OP_ADD..OP_MAD (0..9) and OP_MAX=9.
REQ-032 Exactly one instance of the existing functional_unit SHALL be the sole datapath; no arithmetic is duplicated in fu_arbiter.
REQ-033 The round-robin winner search SHALL be combinational logic inside fu_arbiter, not a separate module.

Verification
REQ-034 Single op: req0 m=2 n=5 sel=1 -> accepted cycle T; rsp at T+2 with rsp_data=0xFD, rsp_id=0, rsp_err=0.
REQ-035 Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; op_count=5 after 5 responses.
REQ-036 Backpressure: m=15 n=0 sel=9, rsp_ready low for 6 cycles -> rsp_data=45 (0x2D) stable and no req_ready asserted until the handshake.
REQ-037 Illegal opcode: sel=12 -> rsp_data=0, rsp_err=1; sel=8 with m=5 -> rsp_data=0xFA.
REQ-038 Reset mid-EXEC: rst_n pulsed low -> rsp_valid stays 0; the next grant goes to requester 0.
REQ-039 Withdrawal and wrap: req2 lowers req_valid while waiting -> never granted; op_count preset near 0xFFFF wraps to 0.
